// File: rtl/alu_serial_nbit.sv
// Bit-serial N-bit ALU: one 1-bit slice with a registered carry, one bit per clock, LSB first.
// Result and C/Z/N/V flags are registered and change only on the done pulse or reset.
//
// state | meaning
// IDLE  | waiting for start; result/flags hold the last completed operation
// RUN   | processing bit cnt of the latched operands
module alu_serial_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mode,
  input  logic [2:0]       opsel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             mode_q;
  logic [2:0]       opsel_q;
  logic             carry;
  logic             prev_a;

  logic             accept;
  logic             last_bit;
  logic             a_bit, b_bit, bx;
  logic             s_bit, c_nxt;
  logic             cin_init;
  logic [WIDTH-1:0] res_sh;
  logic             c_flag, v_flag;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == RUN);
  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == RUN) && (cnt == LAST);
  assign a_bit    = a_sr[0];
  assign b_bit    = b_sr[0];

  // Carry-in preload; SBC borrows the stored C flag as seen at accept time.
  always_comb begin
    cin_init = 1'b0;
    if (!mode) begin
      case (opsel)
        3'b001:                 cin_init = cout;
        3'b011, 3'b100, 3'b110: cin_init = 1'b1;
        default:                cin_init = 1'b0;
      endcase
    end
  end

  // The single 1-bit slice.
  always_comb begin
    bx    = 1'b0;
    s_bit = 1'b0;
    c_nxt = 1'b0;
    if (!mode_q) begin
      case (opsel_q)
        3'b000, 3'b110: bx = b_bit;
        3'b001, 3'b011: bx = ~b_bit;
        3'b101:         bx = 1'b1;
        default:        bx = 1'b0;
      endcase
      if (opsel_q != 3'b111) begin
        s_bit = a_bit ^ bx ^ carry;
        c_nxt = (a_bit & bx) | (a_bit & carry) | (bx & carry);
      end
    end else begin
      case (opsel_q)
        3'b000:  s_bit = a_bit & b_bit;
        3'b001:  s_bit = a_bit | b_bit;
        3'b010:  s_bit = a_bit ^ b_bit;
        3'b011:  s_bit = ~a_bit;
        3'b101:  s_bit = prev_a;
        default: s_bit = 1'b0;
      endcase
    end
  end

  assign res_sh = {s_bit, res_sr};

  always_comb begin
    c_flag = 1'b0;
    v_flag = 1'b0;
    if (!mode_q) begin
      if (opsel_q != 3'b111) begin
        c_flag = c_nxt;
        v_flag = carry ^ c_nxt;
      end
    end else if (opsel_q == 3'b101) begin
      c_flag = a_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      mode_q  <= 1'b0;
      opsel_q <= 3'b000;
      carry   <= 1'b0;
      prev_a  <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sr    <= A;
        b_sr    <= B;
        mode_q  <= mode;
        opsel_q <= opsel;
        carry   <= cin_init;
        prev_a  <= 1'b0;
        res_sr  <= '0;
        cnt     <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        carry  <= c_nxt;
        prev_a <= a_bit;
        res_sr <= res_sh[WIDTH-1:1];
        cnt    <= cnt + CW'(1);
        if (last_bit) begin
          cnt    <= '0;
          result <= res_sh;
          cout   <= c_flag;
          zero   <= (res_sh == '0);
          neg    <= s_bit;
          ovf    <= v_flag;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_nbit.sv
// Scoreboard bench for alu_serial_nbit (WIDTH=8): directed vectors push expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_serial_nbit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         mode = 1'b0;
  logic [2:0]   opsel = 3'b000;
  logic         busy, done, cout, zero, neg, ovf;
  logic [W-1:0] result;

  alu_serial_nbit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .mode(mode), .opsel(opsel),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c, z, n, v;
    int           start_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else if (done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("cout", cout, e.c);
        chk("zero", zero, e.z);
        chk("neg", neg, e.n);
        chk("ovf", ovf, e.v);
        chk("done_latency", cyc - e.start_cyc, W);
        chk("busy_cycles", busy_cnt, W);
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end
  end

  task automatic push_exp(input logic [W-1:0] er, input logic ec, input logic ev);
    exp_t e;
    e.res = er;
    e.c = ec;
    e.z = (er == '0);
    e.n = er[W-1];
    e.v = ev;
    e.start_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic drive_start(input logic [W-1:0] ai, input logic [W-1:0] bi,
                             input logic mi, input logic [2:0] oi,
                             input logic [W-1:0] er, input logic ec, input logic ev);
    a = ai; b = bi; mode = mi; opsel = oi; start = 1'b1;
    @(posedge clk);
    #1;
    push_exp(er, ec, ev);
    start = 1'b0;
  endtask

  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic mi, input logic [2:0] oi,
                       input logic [W-1:0] er, input logic ec, input logic ev);
    @(negedge clk);
    drive_start(ai, bi, mi, oi, er, ec, ev);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 1, 0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [W-1:0] ai, input logic [W-1:0] bi,
                     input logic mi, input logic [2:0] oi,
                     input logic [W-1:0] er, input logic ec, input logic ev);
    issue(ai, bi, mi, oi, er, ec, ev);
    wait_idle();
  endtask

  initial begin
    int n;
    int dc;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_flags", {busy, done, cout, zero, neg, ovf}, 0);
    rst = 1'b0;

    // ADD overflow
    run(8'h7F, 8'h01, 1'b0, 3'b000, 8'h80, 1'b0, 1'b1);

    // SUB then back-to-back SBC issued in the done cycle
    issue(8'h05, 8'h05, 1'b0, 3'b011, 8'h00, 1'b1, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    chk("b2b_done_seen", done, 1);
    drive_start(8'h10, 8'h01, 1'b0, 3'b001, 8'h0F, 1'b1, 1'b0);
    wait_idle();

    // DEC / INC wrap
    run(8'h00, 8'h00, 1'b0, 3'b101, 8'hFF, 1'b0, 1'b0);
    run(8'hFF, 8'h00, 1'b0, 3'b100, 8'h00, 1'b1, 1'b0);

    // Logic set
    run(8'hA5, 8'h0F, 1'b1, 3'b000, 8'h05, 1'b0, 1'b0);
    run(8'hA5, 8'h0F, 1'b1, 3'b001, 8'hAF, 1'b0, 1'b0);
    run(8'hA5, 8'h0F, 1'b1, 3'b010, 8'hAA, 1'b0, 1'b0);
    run(8'hA5, 8'h0F, 1'b1, 3'b011, 8'h5A, 1'b0, 1'b0);
    run(8'hA5, 8'h0F, 1'b1, 3'b101, 8'h4A, 1'b1, 1'b0);
    run(8'hA5, 8'h0F, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0);

    // Start while busy is ignored
    dc = done_cnt;
    issue(8'h01, 8'h01, 1'b0, 3'b000, 8'h02, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    chk("busy_start_done_count", done_cnt - dc, 1);

    // Reset mid-operation aborts with no done
    dc = done_cnt;
    issue(8'h10, 8'h20, 1'b0, 3'b000, 8'h30, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_result", result, 0);
    chk("midrst_flags", {busy, done, cout, zero, neg, ovf}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", done_cnt - dc, 0);

    run(8'h10, 8'h20, 1'b0, 3'b000, 8'h30, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
